// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle restoring divider: unsigned WIDTH-bit quotient and remainder,
// one quotient bit per clock. Each trial subtraction is S + ~D + 1 through an
// explicit ripple chain of full-adder cells; a carry-out of 1 means no borrow.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        request, sampled only in IDLE
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   busy         high while iterating (RUN)
//   done         single-cycle pulse when results are valid
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  last completed operation had divisor 0
//
// Latency: start sampled at the edge ending cycle 0 -> busy in cycles
// 1..WIDTH, done with results in cycle WIDTH+1. Divisor 0 -> done in cycle 1.
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] q_reg;    // dividend shift register, becomes quotient
    logic [WIDTH-1:0] d_reg;    // latched divisor
    logic [WIDTH:0]   r_reg;    // partial remainder, one guard bit
    logic [CW-1:0]    cnt;      // completed iterations

    logic [WIDTH:0]   s_val;    // shifted partial remainder
    logic [WIDTH:0]   b_val;    // inverted, zero-extended divisor
    logic [WIDTH:0]   t_val;    // S - D
    logic             chain_c;  // ripple carry through the adder chain
    logic             no_borrow;
    logic             last_iter;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   r_next;

    // ------------------------------------------------------------------
    // Trial subtraction: full-adder cells, carry-in 1, divisor inverted.
    // ------------------------------------------------------------------
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path leaves it holding its old value (no latch inferred).
    always_comb begin
        s_val   = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        b_val   = ~{1'b0, d_reg};
        t_val   = '0;
        chain_c = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            t_val[i] = s_val[i] ^ b_val[i] ^ chain_c;
            chain_c  = (s_val[i] & b_val[i]) | (chain_c & (s_val[i] ^ b_val[i]));
        end
        no_borrow = chain_c;
        q_shift   = {q_reg[WIDTH-2:0], no_borrow};
        r_next    = no_borrow ? t_val : s_val;
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs (pure state decode, so no
    // input reaches busy/done combinationally)
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers. Results are loaded on the edge that
    // enters DONE so they are visible in the same cycle as the done pulse,
    // and then hold through IDLE until the next operation completes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        cnt   <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q_reg <= q_shift;
                    r_reg <= r_next;
                    cnt   <= cnt + CW'(1);
                    if (last_iter) begin
                        quotient    <= q_shift;
                        remainder   <= r_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Self-checking bench for seq_divider at WIDTH=8 (directed table, handshake
// and reset sequences, random sweep) and WIDTH=16 (random sweep).
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic [7:0] dividend8 = '0, divisor8 = '0;
    logic       busy8, done8, dz8;
    logic [7:0] quotient8, remainder8;

    seq_divider #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .dividend    (dividend8),
        .divisor     (divisor8),
        .busy        (busy8),
        .done        (done8),
        .quotient    (quotient8),
        .remainder   (remainder8),
        .div_by_zero (dz8)
    );

    // WIDTH=16 instance
    logic        start16 = 1'b0;
    logic [15:0] dividend16 = '0, divisor16 = '0;
    logic        busy16, done16, dz16;
    logic [15:0] quotient16, remainder16;

    seq_divider #(.WIDTH(16)) dut16 (
        .clk         (clk),
        .rst         (rst),
        .start       (start16),
        .dividend    (dividend16),
        .divisor     (divisor16),
        .busy        (busy16),
        .done        (done16),
        .quotient    (quotient16),
        .remainder   (remainder16),
        .div_by_zero (dz16)
    );

    int total   = 0;
    int passed  = 0;
    int overlap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // One operation on the 8-bit DUT; cycle 1 is the cycle after start is sampled.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r, output logic dz,
                           output int dcyc, output int bcnt, output logic dafter);
        dcyc = -1; bcnt = 0; q = '0; r = '0; dz = 1'b0;
        @(negedge clk);
        start8 = 1'b1; dividend8 = a; divisor8 = b;
        for (int c = 1; c <= 40 && dcyc < 0; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (busy8) bcnt++;
            if (busy8 && done8) overlap++;
            if (done8) begin
                dcyc = c; q = quotient8; r = remainder8; dz = dz8;
            end
        end
        @(negedge clk);
        dafter = done8;
    endtask

    task automatic run_op16(input logic [15:0] a, input logic [15:0] b,
                            output logic [15:0] q, output logic [15:0] r,
                            output int dcyc, output logic dafter);
        dcyc = -1; q = '0; r = '0;
        @(negedge clk);
        start16 = 1'b1; dividend16 = a; divisor16 = b;
        for (int c = 1; c <= 60 && dcyc < 0; c++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (busy16 && done16) overlap++;
            if (done16) begin
                dcyc = c; q = quotient16; r = remainder16;
            end
        end
        @(negedge clk);
        dafter = done16;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  q8, r8;
        logic [15:0] q16, r16;
        logic        dz, dafter;
        int          dcyc, bcnt, dcount;
        int          dcycs[$];
        logic [7:0]  qs[$], rs[$];

        vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  dz: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0};
        vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0};
        vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0};
        vecs[4] = '{a: 8'd42,  b: 8'd0,   q: 8'd255, r: 8'd42, dz: 1'b1};
        vecs[5] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,  dz: 1'b0};
        vecs[6] = '{a: 8'd1,   b: 8'd255, q: 8'd0,   r: 8'd1,  dz: 1'b0};
        vecs[7] = '{a: 8'd7,   b: 8'd7,   q: 8'd1,   r: 8'd0,  dz: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy",      32'(busy8),      32'd0);
        check("reset done",      32'(done8),      32'd0);
        check("reset quotient",  32'(quotient8),  32'd0);
        check("reset remainder", 32'(remainder8), 32'd0);
        check("reset dz",        32'(dz8),        32'd0);

        // rst overrides start in the same cycle
        rst = 1'b1; start8 = 1'b1; dividend8 = 8'd100; divisor8 = 8'd7;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        @(negedge clk);
        check("rst over start busy", 32'(busy8), 32'd0);

        // Directed table
        foreach (vecs[i]) begin
            run_op8(vecs[i].a, vecs[i].b, q8, r8, dz, dcyc, bcnt, dafter);
            check($sformatf("vec%0d quotient", i),  32'(q8), 32'(vecs[i].q));
            check($sformatf("vec%0d remainder", i), 32'(r8), 32'(vecs[i].r));
            check($sformatf("vec%0d dz", i),        32'(dz), 32'(vecs[i].dz));
            check($sformatf("vec%0d done cycle", i), 32'(dcyc), vecs[i].dz ? 32'd1 : 32'd9);
            check($sformatf("vec%0d busy cycles", i), 32'(bcnt), vecs[i].dz ? 32'd0 : 32'd8);
            check($sformatf("vec%0d done single", i), 32'(dafter), 32'd0);
        end

        // Handshake: extra starts in RUN (cycle 3) and DONE (cycle 9) ignored,
        // start in cycle 10 (first IDLE after DONE) accepted.
        @(negedge clk);
        start8 = 1'b1; dividend8 = 8'd200; divisor8 = 8'd3;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done8) begin
                dcycs.push_back(c); qs.push_back(quotient8); rs.push_back(remainder8);
            end
            if (c == 10) check("hs idle after done busy", 32'(busy8), 32'd0);
            if (c == 11) check("hs restart busy", 32'(busy8), 32'd1);
            start8    = (c == 3 || c == 9 || c == 10);
            dividend8 = (c == 10) ? 8'd50 : 8'd9;
            divisor8  = (c == 10) ? 8'd6  : 8'd9;
        end
        check("hs done count", 32'(dcycs.size()), 32'd2);
        if (dcycs.size() == 2) begin
            check("hs done1 cycle", 32'(dcycs[0]), 32'd9);
            check("hs quotient1",   32'(qs[0]),    32'd66);
            check("hs remainder1",  32'(rs[0]),    32'd2);
            check("hs done2 cycle", 32'(dcycs[1]), 32'd19);
            check("hs quotient2",   32'(qs[1]),    32'd8);
            check("hs remainder2",  32'(rs[1]),    32'd2);
        end

        // Reset abort in cycle 4 of a 100/7 run
        dcount = 0;
        @(negedge clk);
        start8 = 1'b1; dividend8 = 8'd100; divisor8 = 8'd7;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) dcount++;
            if (c == 5) begin
                check("abort busy",      32'(busy8),      32'd0);
                check("abort quotient",  32'(quotient8),  32'd0);
                check("abort remainder", 32'(remainder8), 32'd0);
            end
            rst = (c == 4);
        end
        check("abort no done", 32'(dcount), 32'd0);
        run_op8(8'd100, 8'd7, q8, r8, dz, dcyc, bcnt, dafter);
        check("post-abort quotient",  32'(q8),   32'd14);
        check("post-abort remainder", 32'(r8),   32'd2);
        check("post-abort done cycle", 32'(dcyc), 32'd9);

        // Random sweep, WIDTH=8
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run_op8(a, b, q8, r8, dz, dcyc, bcnt, dafter);
            check($sformatf("rnd8 %0d/%0d quotient", a, b),  32'(q8), 32'(a / b));
            check($sformatf("rnd8 %0d/%0d remainder", a, b), 32'(r8), 32'(a % b));
            check($sformatf("rnd8 %0d/%0d done once", a, b),
                  32'((dcyc == 9) && !dafter), 32'd1);
        end

        // Directed and random sweep, WIDTH=16
        run_op16(16'd60000, 16'd7, q16, r16, dcyc, dafter);
        check("w16 60000/7 quotient",  32'(q16),  32'd8571);
        check("w16 60000/7 remainder", 32'(r16),  32'd3);
        check("w16 60000/7 done cycle", 32'(dcyc), 32'd17);
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] a, b;
            a = 16'($urandom_range(0, 65535));
            b = (n % 2 == 0) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 300));
            run_op16(a, b, q16, r16, dcyc, dafter);
            check($sformatf("rnd16 %0d/%0d quotient", a, b),  32'(q16), 32'(a / b));
            check($sformatf("rnd16 %0d/%0d remainder", a, b), 32'(r16), 32'(a % b));
            check($sformatf("rnd16 %0d/%0d done once", a, b),
                  32'((dcyc == 17) && !dafter), 32'd1);
        end

        check("busy and done never overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring divider, the inverse datapath of the approximate multiplier. It computes an unsigned WIDTH-bit quotient and remainder, one quotient bit per clock. Each trial subtraction runs through a ripple chain of full-adder cells with the divisor inverted and carry-in 1. The block sits beside the multiplier as the divide engine and uses a start/busy/done handshake.

## Interface
- WIDTH, 8, operand, quotient and remainder width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend; sampled with start
- divisor  input  WIDTH  unsigned divisor; sampled with start
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse when results are valid
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered flag: last completed operation had divisor 0

## Operation
- States:
  - IDLE: waits for start.
  - RUN: iterates.
  - DONE: one cycle, then returns to IDLE.
- IDLE with start=1:
  - Latch dividend into shift register Q and divisor into D.
  - Clear partial remainder R (WIDTH+1 bits) and iteration counter.
  - If divisor==0, go to DONE; otherwise go to RUN.
- RUN, one iteration per cycle:
  - Form S = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Compute T = S − {0,D}, WIDTH+1 bits, via the full-adder chain (S + ~D + 1). Carry-out 1 means no borrow.
  - No borrow: R ← T and Q ← {Q[WIDTH-2:0],1}.
  - Borrow: R ← S and Q ← {Q[WIDTH-2:0],0}.
  - Counter increments. After WIDTH iterations, go to DONE.
- DONE:
  - Normal operation: quotient ← Q, remainder ← R[WIDTH-1:0], div_by_zero ← 0.
  - Divide by zero: quotient ← all ones, remainder ← latched dividend, div_by_zero ← 1.
  - done=1 for exactly this cycle.
- Results hold in IDLE until the next DONE overwrites them.
- start is ignored in RUN and DONE; the operands are not re-sampled.
- Arithmetic is unsigned only. Internal R is WIDTH+1 bits so the trial subtraction never overflows. The results satisfy dividend = quotient·divisor + remainder and remainder < divisor.

## Timing
- Reset (rst=1 at a rising edge): state IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Internal Q/R/D are cleared.
- rst overrides start in the same cycle.
- rst during RUN or DONE aborts the operation. No done is produced and the outputs return to their reset values.
- Latency, with start sampled at the edge ending cycle 0:
  - Normal case: busy=1 in cycles 1..WIDTH. done=1 and the new results are visible in cycle WIDTH+1. busy=0 in that cycle.
  - Divisor 0: busy never rises. done=1 in cycle 1.
- Back-to-back: start=1 in the DONE cycle is ignored. The earliest accepted start is the first IDLE cycle after DONE, so throughput is one operation per WIDTH+2 cycles.
- Outputs are registered; there is no combinational path from any input to any output.
- busy and done are never high in the same cycle.

## Test plan
- WIDTH=8, dividend=100, divisor=7 -> busy high 8 cycles; done in cycle 9; quotient=14, remainder=2, div_by_zero=0.
- Edge operands:
  - 255/1 -> quotient=255, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
  - 255/255 -> quotient=1, remainder=0.
- dividend=42, divisor=0 -> done in cycle 1, busy never high; quotient=255, remainder=42, div_by_zero=1.
- Handshake robustness:
  - Start 200/3, then pulse start with 9/9 in cycles 3 and in the DONE cycle. Both extra pulses are ignored: quotient=66, remainder=2.
  - A new start in the cycle after DONE is accepted.
- Reset behaviour:
  - Assert rst in cycle 4 of a 100/7 run -> next cycle IDLE, busy=0, done never pulses, quotient=remainder=0.
  - A fresh 100/7 afterwards yields 14 r 2.
- Randomized sweep, 1000 operand pairs with divisor≠0, WIDTH=8 and WIDTH=16 -> quotient and remainder match a reference model; done pulses exactly once per start.
